// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the shared word memory and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters and memory).
interface mem_port_arbiter_if #(
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [DW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wd;
    logic [DW-1:0] cpu_rd;
    logic          cpu_ack;
    logic          cpu_err;

    logic          dma_req;
    logic          dma_we;
    logic [DW-1:0] dma_addr;
    logic [DW-1:0] dma_wd;
    logic [DW-1:0] dma_rd;
    logic          dma_ack;
    logic          dma_err;

    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    logic          busy;
    logic          grant_dma;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        output cpu_rd, cpu_ack, cpu_err,
        input  dma_req, dma_we, dma_addr, dma_wd,
        output dma_rd, dma_ack, dma_err,
        output mem_addr, mem_wd, mem_we,
        input  mem_rd,
        output busy, grant_dma
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_ack, cpu_err,
        output dma_req, dma_we, dma_addr, dma_wd,
        input  dma_rd, dma_ack, dma_err,
        input  mem_addr, mem_wd, mem_we,
        output mem_rd,
        input  busy, grant_dma
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one word memory between CPU and DMA ports: IDLE -> ACCESS (+wait states) -> DONE.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_port_arbiter #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned DW          = 32
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wd_q;
    logic          we_q;
    logic          grant_q;
    logic          mem_we_q;
    logic          cpu_ack_q, dma_ack_q;
    logic          cpu_err_q, dma_err_q;
    logic [DW-1:0] cpu_rd_q, dma_rd_q;
`ifdef MEM_ARB_RR_EN
    logic          prio_dma_q;
`endif

    logic          pick_dma;
    logic [DW-1:0] sel_addr;
    logic [DW-1:0] sel_wd;
    logic          sel_we;
    logic          aligned;
    logic [DW-1:0] rdata;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        pick_dma = bus.dma_req && (!bus.cpu_req || prio_dma_q);
`else
        pick_dma = bus.dma_req && !bus.cpu_req;
`endif
        sel_addr = pick_dma ? bus.dma_addr : bus.cpu_addr;
        sel_wd   = pick_dma ? bus.dma_wd   : bus.cpu_wd;
        sel_we   = pick_dma ? bus.dma_we   : bus.cpu_we;
        aligned  = (addr_q[1:0] == 2'b00);
        // Writes and misaligned accesses return zero rather than whatever the memory shows.
        rdata    = (!we_q && aligned) ? bus.mem_rd : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            we_q       <= 1'b0;
            grant_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            cpu_err_q  <= 1'b0;
            dma_err_q  <= 1'b0;
            cpu_rd_q   <= '0;
            dma_rd_q   <= '0;
`ifdef MEM_ARB_RR_EN
            prio_dma_q <= 1'b0;
`endif
        end else begin
            mem_we_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            cpu_err_q <= 1'b0;
            dma_err_q <= 1'b0;
            cpu_rd_q  <= '0;
            dma_rd_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        state_q  <= StAccess;
                        cnt_q    <= WaitLoad;
                        addr_q   <= sel_addr;
                        wd_q     <= sel_wd;
                        we_q     <= sel_we;
                        grant_q  <= pick_dma;
                        // mem_we is registered, so it is raised on entry to the final ACCESS cycle.
                        mem_we_q <= (WaitLoad == 4'd0) && sel_we && (sel_addr[1:0] == 2'b00);
`ifdef MEM_ARB_RR_EN
                        prio_dma_q <= !pick_dma;
`endif
                    end
                end
                StAccess: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q    <= cnt_q - 4'd1;
                        mem_we_q <= (cnt_q == 4'd1) && we_q && aligned;
                    end else begin
                        state_q <= StDone;
                        if (grant_q) begin
                            dma_ack_q <= 1'b1;
                            dma_rd_q  <= rdata;
                            dma_err_q <= !aligned;
                        end else begin
                            cpu_ack_q <= 1'b1;
                            cpu_rd_q  <= rdata;
                            cpu_err_q <= !aligned;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.mem_addr  = (state_q == StAccess) ? addr_q : '0;
    assign bus.mem_wd    = (state_q == StAccess) ? wd_q : '0;
    assign bus.mem_we    = mem_we_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rd    = cpu_rd_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_rd    = dma_rd_q;
    assign bus.dma_err   = dma_err_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.grant_dma = grant_q;

endmodule
